// File: rtl/calc_display.sv
// Display stage after the calculator core: stores digit writes and scans them
// onto a common-anode 7-segment display, masking everything with "Err" on error.
module calc_display #(
    parameter int NDIG     = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wr,
    input  logic [3:0]      data,
    input  logic [3:0]      position,
    input  logic            clr,
    input  logic [1:0]      status,
    output logic [NDIG-1:0] an,
    output logic [6:0]      seg
);

    localparam int IW = $clog2(NDIG);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [3:0] BLANK = 4'd15;

    logic [3:0]    digit [NDIG];
    logic [DW-1:0] div;
    logic [IW-1:0] idx;
    logic          wr_hit;
    logic [3:0]    shown;
    logic [6:0]    seg_next;

    always_comb begin
        wr_hit = wr && (int'(position) < NDIG);
    end

    // Error override only masks the selected code; stored digits stay intact.
    always_comb begin
        shown = digit[idx];
        if (status == 2'b10) begin
            if (int'(idx) <= 1)
                shown = 4'd12;
            else if (int'(idx) == 2)
                shown = 4'd11;
            else
                shown = BLANK;
        end
    end

    always_comb begin
        seg_next = 7'h7F;
        case (shown)
            4'd0:    seg_next = 7'h40;
            4'd1:    seg_next = 7'h79;
            4'd2:    seg_next = 7'h24;
            4'd3:    seg_next = 7'h30;
            4'd4:    seg_next = 7'h19;
            4'd5:    seg_next = 7'h12;
            4'd6:    seg_next = 7'h02;
            4'd7:    seg_next = 7'h78;
            4'd8:    seg_next = 7'h00;
            4'd9:    seg_next = 7'h10;
            4'd10:   seg_next = 7'h3F;
            4'd11:   seg_next = 7'h06;
            4'd12:   seg_next = 7'h2F;
            default: seg_next = 7'h7F;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NDIG; i++)
                digit[i] <= BLANK;
            div <= '0;
            idx <= '0;
            an  <= '1;
            seg <= 7'h7F;
        end else begin
            if (clr) begin
                for (int unsigned i = 0; i < NDIG; i++)
                    digit[i] <= BLANK;
            end else if (wr_hit) begin
                digit[position[IW-1:0]] <= data;
            end

            if (div == DW'(SCAN_DIV - 1)) begin
                div <= '0;
                idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end

            an  <= ~({{(NDIG-1){1'b0}}, 1'b1} << idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display: scan timing, write latency, clear priority,
// error override and mid-scan reset, with hand-computed expected displays.
module tb_calc_display;

    localparam int NDIG     = 8;
    localparam int SCAN_DIV = 4;
    localparam logic [6:0] B = 7'h7F;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr;
    logic [3:0] data;
    logic [3:0] position;
    logic       clr;
    logic [1:0] status;
    logic [7:0] an;
    logic [6:0] seg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic            wr;
        logic            clr;
        logic [3:0]      data;
        logic [3:0]      position;
        logic [1:0]      status;
        logic [7:0][6:0] exp;   // expected seg per position, listed 7 down to 0
        string           name;
    } vec_t;

    vec_t vecs[21];

    calc_display #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
        .clock(clock), .reset(reset), .wr(wr), .data(data),
        .position(position), .clr(clr), .status(status),
        .an(an), .seg(seg)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    // Scan index that drove the edge just taken, counted from reset release.
    function automatic int last_idx();
        return ((cyc - 1) / SCAN_DIV) % NDIG;
    endfunction

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic check_scan(input string nm, input logic [7:0][6:0] exp);
        int li;
        for (int n = 0; n < NDIG * SCAN_DIV; n++) begin
            tick();
            li = last_idx();
            check({nm, " an"}, an, ~(8'b1 << li));
            check({nm, " seg"}, {1'b0, seg}, {1'b0, exp[li]});
        end
    endtask

    task automatic wait_phase(input int ph);
        for (int n = 0; n < NDIG * SCAN_DIV && (cyc % (NDIG * SCAN_DIV)) != ph; n++)
            tick();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 4'd2,  4'd3, 2'b00, {B, B, B, B, 7'h24, B, B, 7'h78}, "wr p3"};
        vecs[1]  = '{1'b1, 1'b0, 4'd5,  4'd9, 2'b00, {B, B, B, B, 7'h24, B, B, 7'h78}, "wr p9 ignored"};
        vecs[2]  = '{1'b1, 1'b0, 4'd0,  4'd8, 2'b00, {B, B, B, B, 7'h24, B, B, 7'h78}, "wr p8 ignored"};
        vecs[3]  = '{1'b1, 1'b0, 4'd1,  4'd0, 2'b00, {B, B, B, B, 7'h24, B, B, 7'h79}, "wr 1 p0"};
        vecs[4]  = '{1'b1, 1'b0, 4'd8,  4'd1, 2'b00, {B, B, B, B, 7'h24, B, 7'h00, 7'h79}, "wr 8 p1"};
        vecs[5]  = '{1'b1, 1'b1, 4'd3,  4'd2, 2'b00, {B, B, B, B, B, B, B, B}, "clr over wr"};
        vecs[6]  = '{1'b1, 1'b0, 4'd9,  4'd0, 2'b00, {B, B, B, B, B, B, B, 7'h10}, "wr 9 p0"};
        vecs[7]  = '{1'b1, 1'b0, 4'd9,  4'd1, 2'b00, {B, B, B, B, B, B, 7'h10, 7'h10}, "wr 9 p1"};
        vecs[8]  = '{1'b1, 1'b0, 4'd9,  4'd2, 2'b00, {B, B, B, B, B, 7'h10, 7'h10, 7'h10}, "wr 9 p2"};
        vecs[9]  = '{1'b0, 1'b0, 4'd0,  4'd0, 2'b10, {B, B, B, B, B, 7'h06, 7'h2F, 7'h2F}, "err"};
        vecs[10] = '{1'b1, 1'b0, 4'd4,  4'd5, 2'b10, {B, B, B, B, B, 7'h06, 7'h2F, 7'h2F}, "err wr p5"};
        vecs[11] = '{1'b0, 1'b0, 4'd0,  4'd0, 2'b00, {B, B, 7'h19, B, B, 7'h10, 7'h10, 7'h10}, "err exit"};
        vecs[12] = '{1'b0, 1'b0, 4'd0,  4'd0, 2'b11, {B, B, 7'h19, B, B, 7'h10, 7'h10, 7'h10}, "status 11"};
        vecs[13] = '{1'b1, 1'b0, 4'd6,  4'd7, 2'b01, {7'h02, B, 7'h19, B, B, 7'h10, 7'h10, 7'h10}, "result wr p7"};
        vecs[14] = '{1'b1, 1'b0, 4'd3,  4'd6, 2'b00, {7'h02, 7'h30, 7'h19, B, B, 7'h10, 7'h10, 7'h10}, "wr 3 p6"};
        vecs[15] = '{1'b1, 1'b0, 4'd10, 4'd4, 2'b00, {7'h02, 7'h30, 7'h19, 7'h3F, B, 7'h10, 7'h10, 7'h10}, "wr dash p4"};
        vecs[16] = '{1'b1, 1'b0, 4'd11, 4'd3, 2'b00, {7'h02, 7'h30, 7'h19, 7'h3F, 7'h06, 7'h10, 7'h10, 7'h10}, "wr E p3"};
        vecs[17] = '{1'b1, 1'b0, 4'd12, 4'd3, 2'b00, {7'h02, 7'h30, 7'h19, 7'h3F, 7'h2F, 7'h10, 7'h10, 7'h10}, "wr r p3"};
        vecs[18] = '{1'b1, 1'b0, 4'd13, 4'd3, 2'b00, {7'h02, 7'h30, 7'h19, 7'h3F, B, 7'h10, 7'h10, 7'h10}, "wr 13 p3"};
        vecs[19] = '{1'b1, 1'b0, 4'd5,  4'd3, 2'b00, {7'h02, 7'h30, 7'h19, 7'h3F, 7'h12, 7'h10, 7'h10, 7'h10}, "wr 5 p3"};
        vecs[20] = '{1'b1, 1'b0, 4'd0,  4'd0, 2'b00, {7'h02, 7'h30, 7'h19, 7'h3F, 7'h12, 7'h10, 7'h10, 7'h40}, "wr 0 p0"};

        reset = 1'b1; wr = 1'b0; clr = 1'b0; data = '0; position = '0; status = 2'b00;
        tick();
        tick();
        check("reset an", an, 8'hFF);
        check("reset seg", {1'b0, seg}, {1'b0, 7'h7F});

        // Scan order from release, including the wrap from 7F back to FE.
        reset = 1'b0;
        cyc = 0;
        for (int k = 0; k < 36; k++) begin
            tick();
            check("scan an", an, ~(8'b1 << last_idx()));
            check("scan seg", {1'b0, seg}, {1'b0, B});
        end

        // Write to the selected digit shows up one edge after the write edge.
        wait_phase(0);
        wr = 1'b1; data = 4'd7; position = 4'd0;
        tick();
        wr = 1'b0;
        check("wlat an0", an, 8'hFE);
        check("wlat seg0", {1'b0, seg}, {1'b0, B});
        tick();
        check("wlat an1", an, 8'hFE);
        check("wlat seg1", {1'b0, seg}, {1'b0, 7'h78});

        for (int v = 0; v < 21; v++) begin
            wr = vecs[v].wr; clr = vecs[v].clr; data = vecs[v].data;
            position = vecs[v].position; status = vecs[v].status;
            tick();
            wr = 1'b0; clr = 1'b0;
            check_scan(vecs[v].name, vecs[v].exp);
        end

        // Reset at idx=5, div=2 blanks everything and restarts the scan at digit 0.
        wait_phase(22);
        reset = 1'b1;
        tick();
        check("midrst an", an, 8'hFF);
        check("midrst seg", {1'b0, seg}, {1'b0, B});
        reset = 1'b0;
        cyc = 0;
        check_scan("post reset", {B, B, B, B, B, B, B, B});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
